// File: rtl/rtr_next_hop_addr_vc_pkg.sv
// Shared constants, types and helpers for the lookahead next-hop address unit.
package rtr_next_hop_addr_vc_pkg;

    localparam int CONNECTIVITY_LINE = 0;
    localparam int CONNECTIVITY_RING = 1;
    localparam int CONNECTIVITY_FULL = 2;

    localparam int ROUTING_TYPE_PHASED_DOR = 0;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    // Ceiling log2; a single-entry range needs zero bits.
    function automatic int clogb(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Modulo increment over 0..max_value (ring wrap, any radix).
    function automatic int c_incr(input int value, input int max_value);
        int result;
        if (value >= max_value) begin
            result = 32'sd0;
        end else begin
            result = value + 32'sd1;
        end
        return result;
    endfunction

    // Modulo decrement over 0..max_value (ring wrap, any radix).
    function automatic int c_decr(input int value, input int max_value);
        int result;
        if (value <= 32'sd0) begin
            result = max_value;
        end else begin
            result = value - 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rtr_next_hop_addr_vc_chk.sv
// Simulation checker: at most one VC may be selected for an accepted flit.
module rtr_next_hop_addr_vc_chk #(
    parameter int num_vcs = 4
) (
    input logic               clk,
    input logic               reset,
    input logic               flit_valid_in,
    input logic [num_vcs-1:0] flit_sel_in_ivc
);

    sel_onehot_a: assert property (@(posedge clk) disable iff (reset)
        flit_valid_in |-> $onehot(flit_sel_in_ivc));

endmodule

// File: rtl/rtr_next_hop_dim.sv
// Single-dimension next-coordinate computation with route error flag.
module rtr_next_hop_dim
    import rtr_next_hop_addr_vc_pkg::*;
#(
    parameter int num_routers_per_dim = 4,
    parameter int connectivity        = CONNECTIVITY_LINE,
    parameter int dim_index           = 0,
    parameter int port_idx_width      = 3,
    parameter int dim_addr_width      = 2
) (
    input  logic [port_idx_width-1:0] route_port,
    input  logic [dim_addr_width-1:0] coord,
    input  logic [dim_addr_width-1:0] dest_coord,
    output logic [dim_addr_width-1:0] next_coord,
    output logic                      error
);

    localparam logic [dim_addr_width-1:0] max_coord = dim_addr_width'(num_routers_per_dim - 1);

    generate
        if (connectivity == CONNECTIVITY_FULL) begin : g_full
            localparam int first_port = dim_index * (num_routers_per_dim - 1);
            localparam int last_port  = first_port + num_routers_per_dim - 2;

            logic routed_s;
            assign routed_s = (int'(route_port) >= first_port) && (int'(route_port) <= last_port);

            // Jump straight to the destination coordinate; jumping to ourselves is illegal.
            always_comb begin
                next_coord = coord;
                error      = 1'b0;
                if (routed_s) begin
                    next_coord = dest_coord;
                    error      = (dest_coord == coord);
                end else begin
                    next_coord = coord;
                    error      = 1'b0;
                end
            end
        end else begin : g_neighbor
            localparam logic [port_idx_width-1:0] down_port = port_idx_width'(2 * dim_index);
            localparam logic [port_idx_width-1:0] up_port   = port_idx_width'(2 * dim_index + 1);

            // Neighbour topologies never look at the destination coordinate.
            logic unused;
            assign unused = ^dest_coord;

            // Step one hop; a ring wraps, a line flags falling off either end.
            always_comb begin
                next_coord = coord;
                error      = 1'b0;
                if (route_port == up_port) begin
                    if (connectivity == CONNECTIVITY_RING) begin
                        next_coord = dim_addr_width'(c_incr(int'(coord), int'(max_coord)));
                    end else if (coord == max_coord) begin
                        error = 1'b1;
                    end else begin
                        next_coord = coord + dim_addr_width'(1);
                    end
                end else if (route_port == down_port) begin
                    if (connectivity == CONNECTIVITY_RING) begin
                        next_coord = dim_addr_width'(c_decr(int'(coord), int'(max_coord)));
                    end else if (coord == {dim_addr_width{1'b0}}) begin
                        error = 1'b1;
                    end else begin
                        next_coord = coord - dim_addr_width'(1);
                    end
                end else begin
                    next_coord = coord;
                    error      = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rtr_next_hop_addr_vc.sv
// Per-VC registered lookahead next-hop router address with route/sequence error flags.
// Address layout: dimension 0 occupies the most significant coordinate field.
// Destination slice k of dest_info_in sits at bit node_addr_width + k*router_addr_width.
module rtr_next_hop_addr_vc
    import rtr_next_hop_addr_vc_pkg::*;
#(
    parameter int num_vcs              = 4,
    parameter int num_resource_classes = 2,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 1,
    parameter int connectivity         = CONNECTIVITY_LINE,
    parameter int routing_type         = ROUTING_TYPE_PHASED_DOR,
    localparam int dim_addr_width           = clogb(num_routers_per_dim),
    localparam int router_addr_width        = num_dimensions * dim_addr_width,
    localparam int node_addr_width          = clogb(num_nodes_per_router),
    localparam int num_neighbors_per_dim    = (connectivity == CONNECTIVITY_FULL) ? (num_routers_per_dim - 1) : 2,
    localparam int num_ports                = num_dimensions * num_neighbors_per_dim + num_nodes_per_router,
    localparam int port_idx_width           = clogb(num_ports),
    localparam int resource_class_idx_width = clogb(num_resource_classes),
    localparam int dest_info_width          = num_resource_classes * router_addr_width + node_addr_width,
    localparam int lar_info_width           = port_idx_width + resource_class_idx_width
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [router_addr_width-1:0]         router_address,
    input  logic                                 flit_valid_in,
    input  logic                                 flit_head_in,
    input  logic                                 flit_tail_in,
    input  logic [num_vcs-1:0]                   flit_sel_in_ivc,
    input  logic [dest_info_width-1:0]           dest_info_in,
    input  logic [lar_info_width-1:0]            lar_info_in,
    output logic [num_vcs*router_addr_width-1:0] next_router_address_ivc,
    output logic [num_vcs-1:0]                   addr_valid_ivc,
    output logic [num_vcs-1:0]                   update_ivc,
    output logic [num_vcs-1:0]                   error_route_ivc,
    output logic [num_vcs-1:0]                   error_seq_ivc
);

    localparam int first_eject_port = num_dimensions * num_neighbors_per_dim;

    logic [port_idx_width-1:0]    route_port_s;
    logic [router_addr_width-1:0] dest_addr_s;
    logic [router_addr_width-1:0] routed_addr_s;
    logic [num_dimensions-1:0]    dim_error_s;
    logic [router_addr_width-1:0] next_addr_s;
    logic                         route_error_s;
    logic [num_vcs-1:0]           vc_hit_s;

    assign route_port_s = lar_info_in[lar_info_width-1 -: port_idx_width];

    generate
        if (num_resource_classes > 1) begin : g_rcsel
            logic [resource_class_idx_width-1:0] route_rcsel_s;
            assign route_rcsel_s = lar_info_in[resource_class_idx_width-1:0];
            assign dest_addr_s   = dest_info_in[node_addr_width + route_rcsel_s * router_addr_width +: router_addr_width];
        end else begin : g_single_rc
            assign dest_addr_s = dest_info_in[node_addr_width +: router_addr_width];
        end
    endgenerate

    generate
        for (genvar d = 0; d < num_dimensions; d++) begin : g_dim
            localparam int msb = router_addr_width - 1 - d * dim_addr_width;
            rtr_next_hop_dim #(
                .num_routers_per_dim (num_routers_per_dim),
                .connectivity        (connectivity),
                .dim_index           (d),
                .port_idx_width      (port_idx_width),
                .dim_addr_width      (dim_addr_width)
            ) u_dim (
                .route_port (route_port_s),
                .coord      (router_address[msb -: dim_addr_width]),
                .dest_coord (dest_addr_s[msb -: dim_addr_width]),
                .next_coord (routed_addr_s[msb -: dim_addr_width]),
                .error      (dim_error_s[d])
            );
        end
    endgenerate

    // Pick the routed address, or stay put for ejection and out-of-range ports.
    always_comb begin
        next_addr_s   = router_address;
        route_error_s = 1'b0;
        if (int'(route_port_s) >= num_ports) begin
            next_addr_s   = router_address;
            route_error_s = 1'b1;
        end else if (int'(route_port_s) >= first_eject_port) begin
            next_addr_s   = router_address;
            route_error_s = 1'b0;
        end else begin
            next_addr_s   = routed_addr_s;
            route_error_s = |dim_error_s;
        end
    end

    assign vc_hit_s = flit_sel_in_ivc & {num_vcs{flit_valid_in}};

    generate
        for (genvar v = 0; v < num_vcs; v++) begin : g_vc
            vc_state_e                    state_r;
            logic [router_addr_width-1:0] addr_r;
            logic                         update_r;
            logic                         err_route_r;
            logic                         err_seq_r;

            // Packet tracking FSM plus address capture and sticky error flags for this VC.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_r     <= VC_IDLE;
                    addr_r      <= {router_addr_width{1'b0}};
                    update_r    <= 1'b0;
                    err_route_r <= 1'b0;
                    err_seq_r   <= 1'b0;
                end else begin
                    update_r <= vc_hit_s[v] & flit_head_in;
                    if (vc_hit_s[v]) begin
                        if (flit_head_in) begin
                            addr_r <= next_addr_s;
                            if (route_error_s) begin
                                err_route_r <= 1'b1;
                            end
                            if (state_r == VC_ACTIVE) begin
                                err_seq_r <= 1'b1;
                            end
                            state_r <= flit_tail_in ? VC_IDLE : VC_ACTIVE;
                        end else if (state_r == VC_IDLE) begin
                            err_seq_r <= 1'b1;
                        end else if (flit_tail_in) begin
                            state_r <= VC_IDLE;
                        end
                    end
                end
            end

            assign next_router_address_ivc[(num_vcs-v)*router_addr_width-1 -: router_addr_width] = addr_r;
            assign addr_valid_ivc[v]  = (state_r == VC_ACTIVE);
            assign update_ivc[v]      = update_r;
            assign error_route_ivc[v] = err_route_r;
            assign error_seq_ivc[v]   = err_seq_r;
        end
    endgenerate

    rtr_next_hop_addr_vc_chk #(
        .num_vcs (num_vcs)
    ) u_chk (
        .clk             (clk),
        .reset           (reset),
        .flit_valid_in   (flit_valid_in),
        .flit_sel_in_ivc (flit_sel_in_ivc)
    );

endmodule

// File: doc/rtr_next_hop_addr_vc.md
Name: rtr_next_hop_addr_vc

Overview:
Per-VC registered lookahead next-hop address unit for the input controller.
- On each accepted head flit it computes the address of the downstream router from the lookahead route (port + resource class), destination info and the current router address, and holds it per VC.
- Supports line, ring and fully connected dimensions, and flags illegal routes and flit-sequence violations.
- Sits between the input VC buffer write path and the lookahead route-computation stage.

Parameters:
num_vcs, 4, number of VCs tracked per input port
num_resource_classes, 2, resource classes (minimal/adaptive)
num_routers_per_dim, 4, routers per dimension
num_dimensions, 2, network dimensions
num_nodes_per_router, 1, concentration factor
connectivity, `CONNECTIVITY_LINE, LINE / RING / FULL
routing_type, `ROUTING_TYPE_PHASED_DOR, only supported type

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
router_address  in  router_addr_width  current router address; quasi-static
flit_valid_in  in  1  flit accepted this cycle
flit_head_in  in  1  flit is head
flit_tail_in  in  1  flit is tail
flit_sel_in_ivc  in  num_vcs  one-hot VC of incoming flit
dest_info_in  in  dest_info_width  routing info; sampled on head only
lar_info_in  in  lar_info_width  {route_port, route_rcsel}; sampled on head only
next_router_address_ivc  out  num_vcs*router_addr_width  latched next-hop address per VC; VC 0 in MSBs
addr_valid_ivc  out  num_vcs  VC has an open multi-flit packet
update_ivc  out  num_vcs  one-cycle pulse: address captured last cycle
error_route_ivc  out  num_vcs  sticky: illegal route_port or line underflow/overflow
error_seq_ivc  out  num_vcs  sticky: head on active VC, or body/tail on idle VC

Behaviour:
- Reset (async, active-high): all outputs 0; all VC states IDLE; stored addresses 0.
- Port numbering per dimension:
  - LINE/RING: port 2d decrements coordinate d, port 2d+1 increments it.
  - FULL: ports d*(n-1) .. (d+1)*(n-1)-1 set coordinate d to the destination coordinate.
  - Ports >= num_dimensions*num_neighbors_per_dim are ejection; next address equals router_address.
- Destination selection: dest_addr = slice route_rcsel of dest_info_in. With one resource class, slice 0.
- Capture: flit_valid_in & flit_head_in for VC v. At the next clock edge:
  - next_router_address_ivc[v] is loaded.
  - update_ivc[v] is 1 for exactly that cycle. Latency 1 cycle.
- Per-VC FSM:
  - IDLE + head & !tail -> ACTIVE.
  - IDLE + head & tail -> IDLE; address still captured, update pulses.
  - ACTIVE + tail -> IDLE.
  - ACTIVE + body -> ACTIVE.
  - addr_valid_ivc[v] = (state == ACTIVE).
- Sequence errors:
  - Head on ACTIVE VC: set error_seq, re-capture the address, stay ACTIVE (IDLE if tail also set).
  - Body/tail on IDLE VC: set error_seq, no state change.
- Arithmetic:
  - LINE: two's-complement +/-1 on the dim_addr_width coordinate. Coordinate 0 down, or coordinate n-1 up, sets error_route. The stored coordinate is left unchanged in that case.
  - RING: wraps modulo num_routers_per_dim (n-1 up -> 0; 0 down -> n-1). This is correct for non-power-of-2 n.
  - FULL: a destination coordinate equal to the current coordinate on a routed dim sets error_route.
- route_port >= num_ports sets error_route; next address = router_address.
- Error flags are sticky until reset.
- Only one VC is updated per cycle. A flit_sel_in_ivc that is not one-hot while valid is outside the contract; an assertion is reported in simulation.
- Inputs are ignored when flit_valid_in = 0.
- Reset asserted mid-packet returns the VC to IDLE; the stored address clears to 0.

Decomposition:
- c_constants: CONNECTIVITY_*, ROUTING_TYPE_*. Shared functions file: clogb.
- Derived widths are localparams, computed exactly as in the existing routing blocks:
  - dest_info_width = num_resource_classes*router_addr_width + node_addr_width.
  - lar_info_width = port_idx_width + resource_class_idx_width.
- Sub-module rtr_next_hop_dim: combinational single-dimension next-coordinate plus error flag. It is instantiated num_dimensions times and uses c_incr/c_decr for RING.
- Per-VC state and registers live in a generate loop in the top module.

Test Plan:
1. Defaults (LINE, 4x4). router_address=0110, head+!tail on VC0, route_port=1 -> next cycle next_router_address[0]=1010, update_ivc=0001, addr_valid=0001. Tail on VC0 -> addr_valid=0000.
2. LINE, router_address=1100, route_port=1 (dim0 up, coord 3) -> error_route_ivc[VC] set; stored address 1100; flag persists until reset.
3. RING, num_routers_per_dim=3, coord0=2, route_port=1 -> next coord0=0. Coord0=0, route_port=0 -> next coord0=2.
4. FULL, n=4, route_port=4 (dim1), rcsel=1, dest slice1 = 0111, router_address=0100 -> next 0111. route_port=6 (ejection) -> next equals router_address.
5. Single-flit head+tail on VC2 -> update_ivc=0100 for one cycle, addr_valid stays 0. Subsequent body flit on VC2 -> error_seq_ivc[2]=1.
6. Reset asserted asynchronously while VC1 ACTIVE -> all outputs 0 immediately. After deassert, a head on VC1 has no error_seq.
